// File: rtl/sound_noise_ctrl_pkg.sv
// Shared definitions for the noise channel control block and the frame sequencer.
package sound_noise_ctrl_pkg;

  // Register map
  localparam logic [15:0] NR41_ADDR = 16'hFF20;
  localparam logic [15:0] NR42_ADDR = 16'hFF21;
  localparam logic [15:0] NR43_ADDR = 16'hFF22;
  localparam logic [15:0] NR44_ADDR = 16'hFF23;

  // Value returned for write-only or unmapped locations
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  // 4.194304 MHz / 8192 = 512 Hz frame-sequencer step rate
  localparam int unsigned CLK_DIV_DEFAULT      = 8192;
  localparam int unsigned START_CYCLES_DEFAULT = 4;

  // Step-to-pulse tables: bit N set means "pulse on entering step N"
  localparam logic [7:0] LEN_STEP_MASK   = 8'b0101_0101;  // steps 0,2,4,6
  localparam logic [7:0] SWEEP_STEP_MASK = 8'b0100_0100;  // steps 2,6
  localparam logic [7:0] ENV_STEP_MASK   = 8'b1000_0000;  // step 7

  // Frame-sequencer pulse bundle
  typedef struct packed {
    logic length_ctr;
    logic sweep;
    logic vol_env;
  } frame_pulses_t;

  // Stored NR41..NR44 register contents
  typedef struct packed {
    logic [5:0] length;
    logic [3:0] initial_volume;
    logic       envelope_increasing;
    logic [2:0] num_envelope_sweeps;
    logic [3:0] shift_clock_freq;
    logic       counter_width;
    logic [2:0] freq_dividing_ratio;
    logic       single;
  } noise_regs_t;

  // Look up which pulses fire when the sequencer enters a given step
  function automatic frame_pulses_t step_pulses(input logic [2:0] step);
    frame_pulses_t p;
    p.length_ctr = LEN_STEP_MASK[step];
    p.sweep      = SWEEP_STEP_MASK[step];
    p.vol_env    = ENV_STEP_MASK[step];
    return p;
  endfunction

endpackage

// File: rtl/sound_frame_seq.sv
// 512 Hz frame sequencer: divider plus 3-bit step counter driving the
// length / sweep / envelope clock pulses shared by all sound channels.
module sound_frame_seq
  import sound_noise_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sound_on,
  output logic clk_length_ctr,
  output logic clk_vol_env,
  output logic clk_sweep
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  // Index of the step entered at the next divider wrap
  logic [2:0]       r_step;
  frame_pulses_t    r_pulses;
  frame_pulses_t    w_step_pulses;
  logic             w_wrap;

  assign w_wrap        = (r_div == DIV_LAST);
  assign w_step_pulses = step_pulses(r_step);

  // Divider, step counter and one-cycle pulse registers; all held at zero while sound is off
  always_ff @(posedge clk) begin
    if (rst || !sound_on) begin
      r_div    <= '0;
      r_step   <= '0;
      r_pulses <= '0;
    end else begin
      if (w_wrap) begin
        r_div  <= '0;
        r_step <= r_step + 3'd1;
      end else begin
        r_div  <= r_div + DIV_W'(1);
      end
      r_pulses <= w_wrap ? w_step_pulses : '0;
    end
  end

  assign clk_length_ctr = r_pulses.length_ctr;
  assign clk_sweep      = r_pulses.sweep;
  assign clk_vol_env    = r_pulses.vol_env;

endmodule

// File: rtl/sound_noise_ctrl.sv
// Noise channel (NR41..NR44) register block: CPU decode, readback,
// trigger pulse generation and the channel's frame sequencer.
module sound_noise_ctrl
  import sound_noise_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV      = CLK_DIV_DEFAULT,
  parameter int unsigned START_CYCLES = START_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        wr,
  input  logic        sound_on,
  output logic [5:0]  length,
  output logic [3:0]  initial_volume,
  output logic        envelope_increasing,
  output logic [2:0]  num_envelope_sweeps,
  output logic [3:0]  shift_clock_freq,
  output logic        counter_width,
  output logic [2:0]  freq_dividing_ratio,
  output logic        single,
  output logic        start,
  output logic        clk_length_ctr,
  output logic        clk_vol_env,
  output logic        clk_sweep,
  output logic        dac_en
);

  // Counter holds the remaining pulse cycles after the current one
  localparam int unsigned     CNT_W      = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);

  noise_regs_t      r_regs;
  logic             r_start;
  logic [CNT_W-1:0] r_start_cnt;

  logic w_wr_en;
  logic w_wr_nr41;
  logic w_wr_nr42;
  logic w_wr_nr43;
  logic w_wr_nr44;
  logic w_trigger;

  // Reads have no side effects, so the read strobe is not needed
  logic w_unused_rd;
  assign w_unused_rd = rd;

  // Write decode; writes are ignored while the APU is powered off
  assign w_wr_en   = wr && sound_on;
  assign w_wr_nr41 = w_wr_en && (a == NR41_ADDR);
  assign w_wr_nr42 = w_wr_en && (a == NR42_ADDR);
  assign w_wr_nr43 = w_wr_en && (a == NR43_ADDR);
  assign w_wr_nr44 = w_wr_en && (a == NR44_ADDR);
  assign w_trigger = w_wr_nr44 && din[7];

  // Register file; powering off clears every field
  always_ff @(posedge clk) begin
    if (rst || !sound_on) begin
      r_regs <= '0;
    end else begin
      if (w_wr_nr41) begin
        r_regs.length <= din[5:0];
      end
      if (w_wr_nr42) begin
        r_regs.initial_volume      <= din[7:4];
        r_regs.envelope_increasing <= din[3];
        r_regs.num_envelope_sweeps <= din[2:0];
      end
      if (w_wr_nr43) begin
        r_regs.shift_clock_freq    <= din[7:4];
        r_regs.counter_width       <= din[3];
        r_regs.freq_dividing_ratio <= din[2:0];
      end
      if (w_wr_nr44) begin
        r_regs.single <= din[6];
      end
    end
  end

  // Trigger pulse: a new trigger reloads the counter so overlapping triggers merge
  always_ff @(posedge clk) begin
    if (rst || !sound_on) begin
      r_start     <= 1'b0;
      r_start_cnt <= '0;
    end else if (w_trigger) begin
      r_start     <= 1'b1;
      r_start_cnt <= START_LOAD;
    end else if (r_start_cnt != '0) begin
      r_start_cnt <= r_start_cnt - CNT_W'(1);
    end else begin
      r_start     <= 1'b0;
    end
  end

  // CPU readback; NR41 is write-only and NR44 exposes only the single bit
  always_comb begin
    dout = OPEN_BUS;
    case (a)
      NR42_ADDR: dout = {r_regs.initial_volume, r_regs.envelope_increasing,
                         r_regs.num_envelope_sweeps};
      NR43_ADDR: dout = {r_regs.shift_clock_freq, r_regs.counter_width,
                         r_regs.freq_dividing_ratio};
      NR44_ADDR: dout = {1'b1, r_regs.single, 6'h3F};
      default:   dout = OPEN_BUS;
    endcase
  end

  // Channel frame sequencer
  sound_frame_seq #(
    .CLK_DIV (CLK_DIV)
  ) u_frame_seq (
    .clk            (clk),
    .rst            (rst),
    .sound_on       (sound_on),
    .clk_length_ctr (clk_length_ctr),
    .clk_vol_env    (clk_vol_env),
    .clk_sweep      (clk_sweep)
  );

  assign length              = r_regs.length;
  assign initial_volume      = r_regs.initial_volume;
  assign envelope_increasing = r_regs.envelope_increasing;
  assign num_envelope_sweeps = r_regs.num_envelope_sweeps;
  assign shift_clock_freq    = r_regs.shift_clock_freq;
  assign counter_width       = r_regs.counter_width;
  assign freq_dividing_ratio = r_regs.freq_dividing_ratio;
  assign single              = r_regs.single;
  assign start               = r_start;
  // DAC is powered whenever volume or envelope direction is non-zero
  assign dac_en              = (r_regs.initial_volume != 4'd0) || r_regs.envelope_increasing;

endmodule

// File: tb/tb_sound_noise_ctrl.sv
// Scoreboard bench for sound_noise_ctrl with a cycle-count based reference model.
module tb_sound_noise_ctrl;

  localparam int unsigned CLK_DIV      = 8;
  localparam int unsigned START_CYCLES = 4;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd;
  logic        wr;
  logic        sound_on;
  logic [5:0]  length;
  logic [3:0]  initial_volume;
  logic        envelope_increasing;
  logic [2:0]  num_envelope_sweeps;
  logic [3:0]  shift_clock_freq;
  logic        counter_width;
  logic [2:0]  freq_dividing_ratio;
  logic        single;
  logic        start;
  logic        clk_length_ctr;
  logic        clk_vol_env;
  logic        clk_sweep;
  logic        dac_en;

  sound_noise_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .START_CYCLES (START_CYCLES)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .a                   (a),
    .din                 (din),
    .dout                (dout),
    .rd                  (rd),
    .wr                  (wr),
    .sound_on            (sound_on),
    .length              (length),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .shift_clock_freq    (shift_clock_freq),
    .counter_width       (counter_width),
    .freq_dividing_ratio (freq_dividing_ratio),
    .single              (single),
    .start               (start),
    .clk_length_ctr      (clk_length_ctr),
    .clk_vol_env         (clk_vol_env),
    .clk_sweep           (clk_sweep),
    .dac_en              (dac_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [22:0] fields;
    logic [2:0] pulses;
    logic       start;
    logic       dac;
    logic [7:0] dout;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: register bytes, edges since power-on, last trigger edge
  logic [5:0] m_nr41;
  logic [7:0] m_nr42;
  logic [7:0] m_nr43;
  logic       m_single;
  int         on_cnt    = 0;
  int         trig_edge = -1;
  int         edge_n    = 0;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] addr);
    logic [7:0] v;
    case (addr)
      16'hFF21: v = m_nr42;
      16'hFF22: v = m_nr43;
      16'hFF23: v = {2'b11, 6'h3F} & {1'b1, m_single, 6'h3F};
      default:  v = 8'hFF;
    endcase
    return v;
  endfunction

  // Drive one cycle of inputs and push what the DUT must show after the next edge
  task automatic drive(input bit r, input bit on, input bit w, input logic [15:0] addr, input logic [7:0] d);
    exp_t e;
    int   stp;
    @(negedge clk);
    rst = r; sound_on = on; wr = w; a = addr; din = d; rd = !w;
    edge_n++;
    e.pulses = 3'b000;
    if (r || !on) begin
      m_nr41 = '0; m_nr42 = '0; m_nr43 = '0; m_single = 1'b0;
      on_cnt = 0; trig_edge = -1;
    end else begin
      on_cnt++;
      if (on_cnt % CLK_DIV == 0) begin
        stp = (on_cnt / CLK_DIV - 1) % 8;
        e.pulses = {(stp % 2 == 0), (stp == 7), (stp % 4 == 2)};
      end
      if (w) begin
        case (addr)
          16'hFF20: m_nr41 = d[5:0];
          16'hFF21: m_nr42 = d;
          16'hFF22: m_nr43 = d;
          16'hFF23: begin
            m_single = d[6];
            if (d[7]) trig_edge = edge_n;
          end
          default: ;
        endcase
      end
    end
    e.cyc    = edge_n;
    e.fields = {m_nr41, m_nr42, m_nr43, m_single};
    e.start  = (trig_edge >= 0) && (edge_n - trig_edge < int'(START_CYCLES));
    e.dac    = (m_nr42[7:3] != 5'd0);
    e.dout   = model_read(addr);
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input logic [15:0] addr);
    for (int i = 0; i < n; i++) drive(0, 1, 0, addr, 8'h00);
  endtask

  // Monitor: every cycle the DUT presents a full output set, compare against the queue head
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("fields", e.cyc, 32'({length, initial_volume, envelope_increasing, num_envelope_sweeps,
                                  shift_clock_freq, counter_width, freq_dividing_ratio, single}),
            32'(e.fields));
      check("pulses(len,env,sweep)", e.cyc, 32'({clk_length_ctr, clk_vol_env, clk_sweep}), 32'(e.pulses));
      check("start", e.cyc, 32'(start), 32'(e.start));
      check("dac_en", e.cyc, 32'(dac_en), 32'(e.dac));
      check("dout", e.cyc, 32'(dout), 32'(e.dout));
    end
  end

  initial begin
    int off_left;
    rst = 1'b1; sound_on = 1'b0; wr = 1'b0; rd = 1'b0; a = 16'h0000; din = 8'h00;
    m_nr41 = '0; m_nr42 = '0; m_nr43 = '0; m_single = 1'b0;

    // Reset state, unmapped read
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 16'h1234, 8'h00);

    // NR42 write and readback
    drive(0, 1, 1, 16'hFF21, 8'hA3);
    idle(2, 16'hFF21);

    // Trigger with single set, read NR44 and NR41
    drive(0, 1, 1, 16'hFF23, 8'hC0);
    idle(3, 16'hFF23);
    idle(3, 16'hFF20);

    // Retrigger two cycles into the pulse
    drive(0, 1, 1, 16'hFF23, 8'h80);
    idle(1, 16'hFF23);
    drive(0, 1, 1, 16'hFF23, 8'h80);
    idle(8, 16'hFF22);

    // Trigger with DAC off still pulses start
    drive(0, 1, 1, 16'hFF21, 8'h00);
    drive(0, 1, 1, 16'hFF23, 8'h80);
    idle(5, 16'hFF21);

    // Full frame: 8 step advances
    drive(1, 1, 0, 16'h0000, 8'h00);
    idle(70, 16'hFF24);

    // Power off mid-frame with writes, then power on again
    drive(0, 1, 1, 16'hFF22, 8'h5C);
    idle(5, 16'hFF22);
    drive(0, 0, 1, 16'hFF21, 8'hF0);
    drive(0, 0, 1, 16'hFF23, 8'h80);
    drive(0, 0, 1, 16'hFF22, 8'h77);
    idle(2 * CLK_DIV + 4, 16'hFF22);

    // Reset during a start pulse with registers programmed
    drive(0, 1, 1, 16'hFF20, 8'h2A);
    drive(0, 1, 1, 16'hFF21, 8'hF7);
    drive(0, 1, 1, 16'hFF22, 8'hFF);
    drive(0, 1, 1, 16'hFF23, 8'hC0);
    idle(1, 16'hFF22);
    drive(1, 1, 0, 16'hFF22, 8'h00);
    idle(3, 16'hFF23);

    // Randomized traffic with occasional power-off and reset
    off_left = 0;
    for (int i = 0; i < 800; i++) begin
      bit          r;
      bit          on;
      bit          w;
      logic [15:0] ad;
      logic [7:0]  d;
      if (off_left > 0) begin
        off_left--;
        on = 1'b0;
      end else begin
        on = 1'b1;
        if ($urandom_range(0, 249) == 0) off_left = $urandom_range(1, 6);
      end
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 9) < 3);
      ad = 16'hFF1F + 16'($urandom_range(0, 5));
      d  = 8'($urandom);
      drive(r, on, w, ad, d);
    end

    idle(3, 16'h0000);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    check("drain", edge_n, 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_noise_ctrl.md
SOUND_NOISE_CTRL -- requirements
Module: sound_noise_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8192: clk cycles per frame-sequencer step (4.194304 MHz / 8192 = 512 Hz).
REQ-002 SHALL have parameter START_CYCLES, default 4: width of the start pulse in clk cycles.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk  in  1  CPU clock.
REQ-005 Port rst  in  1  synchronous active-high reset.
REQ-006 Port a  in  16  CPU bus address.
REQ-007 Port din  in  8  CPU write data.
REQ-008 Port dout  out  8  CPU read data.
REQ-009 Port rd  in  1  read strobe.
REQ-010 Port wr  in  1  write strobe, one write per cycle high.
REQ-011 Port sound_on  in  1  NR52 bit 7 master enable.
REQ-012 Port length, initial_volume, envelope_increasing, num_envelope_sweeps  out  6/4/1/3  fields from NR41/NR42.
REQ-013 Port shift_clock_freq, counter_width, freq_dividing_ratio  out  4/1/3  fields from NR43.
REQ-014 Port single  out  1  NR44 bit 6.
REQ-015 Port start  out  1  trigger pulse to the noise channel.
REQ-016 Port clk_length_ctr, clk_vol_env, clk_sweep  out  1 each  frame-sequencer pulses.
REQ-017 Port dac_en  out  1  high when NR42[7:3] != 0.

Function
REQ-018 SHALL decode 0xFF20 NR41 (length = din[5:0]), 0xFF21 NR42 (vol = din[7:4], inc = din[3], sweeps = din[2:0]), 0xFF22 NR43 (s = din[7:4], width = din[3], r = din[2:0]) and 0xFF23 NR44 (single = din[6], trigger = din[7]).
REQ-019 Register writes SHALL take effect on the clk edge where wr=1; outputs update the following cycle.
REQ-020 dout SHALL be combinational: NR41 0xFF; NR42 and NR43 as stored; NR44 {1, single, 6'h3F}; any other address 0xFF.
REQ-021 A write to NR44 with din[7]=1 SHALL raise start the next cycle and hold it for exactly START_CYCLES cycles.
REQ-022 A trigger write while start is high SHALL reload the start counter, extending the pulse to START_CYCLES from the new write.
REQ-023 A trigger with dac_en=0 SHALL still produce the start pulse; gating is done downstream.
REQ-024 The frame sequencer SHALL use a divider counting 0..CLK_DIV-1 and a 3-bit step counter that advances when the divider wraps; the step wraps 7->0.
REQ-025 On a step advance into step N, the block SHALL drive one-cycle-high pulses: clk_length_ctr for N in {0,2,4,6}; clk_sweep for N in {2,6}; clk_vol_env for N=7.
REQ-026 Pulse rates SHALL be 256 Hz length, 128 Hz sweep and 64 Hz envelope at the default CLK_DIV.
REQ-027 While sound_on=0, the block SHALL clear all stored registers and outputs, ignore writes, hold the divider and step at 0, and emit no pulses.
REQ-028 On the first cycle of sound_on=1, the divider SHALL start from 0.
REQ-029 A simultaneous NR44 trigger and frame pulse SHALL both occur, with neither suppressed.

Reset
REQ-030 rst=1 SHALL clear all registers, the divider, the step counter and the start counter to 0.
REQ-031 rst=1 SHALL force start, all frame pulses and dac_en to 0, and dout SHALL read 0xFF at unmapped addresses.
REQ-032 rst asserted mid-start-pulse SHALL drop start the next cycle.

Structure
REQ-033 A shared package SHALL hold the NR41..NR44 addresses (0xFF20..0xFF23), the default CLK_DIV, and the step-to-pulse table constants.
REQ-034 The frame sequencer SHALL be a sub-module, sound_frame_seq (clk, rst, sound_on -> three pulse outputs), reused by the other channels.

Verification
REQ-035 Write 0xFF21=0xA3 then read -> dout=0xA3; initial_volume=10, envelope_increasing=0, num_envelope_sweeps=3, dac_en=1.
REQ-036 Write 0xFF23=0xC0 -> start high for exactly 4 cycles starting one cycle after wr; single=1; reading 0xFF23 returns 0xFF.
REQ-037 A second 0xFF23=0x80 two cycles into the pulse -> start high 6 cycles total, with no low gap.
REQ-038 With CLK_DIV=8, run 64 cycles -> 8 step advances giving 4 length pulses, 2 sweep pulses (steps 2 and 6) and 1 envelope pulse (step 7), each one cycle wide.
REQ-039 Drop sound_on mid-frame -> all outputs are 0 next cycle and writes are ignored; re-raise -> first length pulse after exactly CLK_DIV cycles.
REQ-040 Assert rst during a start pulse with registers programmed -> start=0 and all fields 0 on the next cycle.
